// File: rtl/mac_accum.sv
// mac_accum: signed fixed-point multiply-accumulate over a configurable
// number of beats per neuron, delivering one saturated pre-activation
// result per neuron through a valid/ready handshake.
module mac_accum #(
    parameter int DataWidth = 16,
    parameter int FracBits  = 8,
    parameter int CntWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CntWidth-1:0]  cfg_len,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    input  logic [DataWidth-1:0] in_weight,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_sat
);

    // Wide enough that 2^CntWidth full-scale products never overflow.
    localparam int AccWidth = 2 * DataWidth + CntWidth;
    localparam int ProdWidth = 2 * DataWidth;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [CntWidth-1:0] CntOne = 1;

    // Saturation bounds of the result format, expressed at accumulator width.
    localparam logic signed [AccWidth-1:0] SatMax =
        {{(AccWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatMin =
        {{(AccWidth-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

    logic [1:0]                  state;
    logic signed [AccWidth-1:0]  acc;
    logic [CntWidth-1:0]         cnt;
    logic [CntWidth-1:0]         len;

    logic signed [ProdWidth-1:0] data_ext;
    logic signed [ProdWidth-1:0] weight_ext;
    logic signed [ProdWidth-1:0] prod;
    logic signed [AccWidth-1:0]  prod_ext;
    logic signed [AccWidth-1:0]  acc_next;
    logic signed [AccWidth-1:0]  shifted;
    logic [CntWidth-1:0]         len_first;
    logic                        first;
    logic                        last;
    logic                        accept;
    logic                        aborting;

    // Ready is a function of state, abort, out_ready and reset only; never of in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            case (state)
                S_OUT:   in_ready = out_ready;
                default: in_ready = !abort;
            endcase
        end
    end

    assign accept   = in_valid && in_ready;
    assign aborting = (state == S_ACC) && abort;

    // Any beat accepted outside S_ACC opens a new neuron (including the
    // beat that rides along with an output handshake).
    assign first = (state != S_ACC);

    // Full-precision product, accumulate, shift and last-beat detection.
    always_comb begin
        data_ext   = {{DataWidth{in_data[DataWidth-1]}}, in_data};
        weight_ext = {{DataWidth{in_weight[DataWidth-1]}}, in_weight};
        prod       = data_ext * weight_ext;
        prod_ext   = {{CntWidth{prod[ProdWidth-1]}}, prod};
        acc_next   = first ? prod_ext : acc + prod_ext;
        shifted    = acc_next >>> FracBits;
        len_first  = (cfg_len == '0) ? CntOne : cfg_len;
        last       = first ? (len_first == CntOne) : ((cnt + CntOne) == len);
    end

    // State, accumulator, counters and registered result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (aborting) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc <= acc_next;
            if (first) begin
                len <= len_first;
                cnt <= CntOne;
            end else begin
                cnt <= cnt + CntOne;
            end
            if (last) begin
                state     <= S_OUT;
                out_valid <= 1'b1;
                if (shifted > SatMax) begin
                    out_data <= SatMax[DataWidth-1:0];
                    out_sat  <= 1'b1;
                end else if (shifted < SatMin) begin
                    out_data <= SatMin[DataWidth-1:0];
                    out_sat  <= 1'b1;
                end else begin
                    out_data <= shifted[DataWidth-1:0];
                    out_sat  <= 1'b0;
                end
            end else begin
                state     <= S_ACC;
                out_valid <= 1'b0;
            end
        end else if (state == S_OUT && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mac_accum.md
# mac_accum

Multiply-accumulate stage directly upstream of the activation stage. It consumes a stream of signed (input, weight) pairs and accumulates their fixed-point products over a configurable number of beats per neuron. It then delivers one saturated pre-activation value per neuron through a valid/ready handshake. The activation stage registers this value and applies ReLU.

## Interface
- `DataWidth`, 16: width of inputs, weights and result; signed two's complement.
- `FracBits`, 8: fractional bits of the fixed-point format (Q(DataWidth-FracBits).FracBits).
- `CntWidth`, 8: width of the beat-count configuration.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cfg_len` in CntWidth: beats per neuron; sampled on the first beat of each neuron; 0 is treated as 1.
- `abort` in 1: discard the partial sum.
- `in_valid` in 1: input pair valid.
- `in_ready` out 1: stage can accept a pair.
- `in_data` in DataWidth: signed input activation.
- `in_weight` in DataWidth: signed weight.
- `out_valid` out 1: pre-activation result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out DataWidth: saturated pre-activation.
- `out_sat` out 1: `out_data` was clipped; qualified by `out_valid`.

## Operation
- Internal accumulator width is AccWidth = 2·DataWidth + CntWidth. It cannot overflow for any legal length.
- Product: full-precision signed `in_data*in_weight` (2·DataWidth bits), sign-extended to AccWidth.
- A beat is accepted when `in_valid && in_ready`.
- States:
  - S_IDLE: no partial sum; `in_ready`=1.
  - S_ACC: partial sum held; `in_ready`=1 unless `abort`=1.
  - S_OUT: result held; `in_ready` = `out_ready`.
- Beat counter `cnt` (CntWidth) and latched length `len`.
  - First beat of a neuron: `acc`←product, `len`←max(cfg_len,1), `cnt`←1.
  - Later beats: `acc`←acc+product, `cnt`←cnt+1.
- Last beat is the accepted beat where (`cnt`+1 == `len`), or the first beat with `len`=1. On the last beat:
  - compute `r = acc_next >>> FracBits` (arithmetic shift, truncation toward −∞);
  - saturate `r` to [−2^(DataWidth−1), 2^(DataWidth−1)−1];
  - register the result into `out_data`, set `out_sat` if clipped, go to S_OUT, assert `out_valid`.
- Transitions:
  - S_IDLE→S_ACC on a non-last accepted beat.
  - S_IDLE→S_OUT on an accepted beat with `len`=1.
  - S_ACC→S_OUT on the last beat.
- S_OUT when `out_ready`=1 (handshake):
  - `out_valid` drops, or stays high if a new result completes in the same cycle.
  - Any beat accepted in the same cycle starts the next neuron: S_ACC, or S_OUT again if `len`=1.
  - With no beat accepted, the next state is S_IDLE.
- S_OUT with `out_ready`=0: `out_data`, `out_sat` and `out_valid` hold stable; no beat is accepted.
- `abort`:
  - In S_ACC: forces `in_ready`=0, clears `acc` and `cnt`, next state S_IDLE.
  - In S_IDLE: no effect beyond `in_ready`=0 that cycle.
  - In S_OUT: ignored; the result is preserved.
- Reset (`rst`=0 at a clock edge, including mid-neuron or while S_OUT):
  - clears `acc`, `cnt`, `len`, `out_data`, `out_sat`, `out_valid`; state S_IDLE.
  - `in_ready` is forced 0 combinationally while `rst`=0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0. `in_ready`=0 during reset and 1 in the first cycle after `rst` returns high.
- Latency: last beat accepted at edge N → `out_valid`=1 with final data after edge N (visible in cycle N+1).
- Throughput: one beat per cycle. With `out_ready` held 1, consecutive neurons run with no bubble, including `len`=1 every cycle.
- `in_ready` depends combinationally on `out_ready`, `abort` and `rst`. There is no combinational path from `in_valid` to `in_ready`.
- `out_valid` never deasserts without a handshake, except on reset.

## Test plan
- Q8.8, `cfg_len`=3, three beats of (256,256) (1.0·1.0) → after the third beat: `out_data`=768, `out_sat`=0, `out_valid` exactly one cycle later.
- `cfg_len`=2, beats (32512,32512) twice → `out_data`=32767, `out_sat`=1. Negative case: `cfg_len`=1, (−512,384) → `out_data`=−768, `out_sat`=0.
- `out_ready`=1, continuous beats, `cfg_len`=2, four neurons → four results on consecutive even cycles, `in_ready` never low. With `cfg_len`=1 → one result every cycle.
- Backpressure: result pending, `out_ready`=0 for 5 cycles with `in_valid`=1:
  - `in_ready`=0 and `out_data` stable throughout;
  - on `out_ready`=1, the handshake and the first next-neuron beat are accepted in the same cycle.
- Abort after 2 of 4 beats, then a fresh 4-beat neuron of (256,256) → `out_data`=1024. No contribution from the aborted beats.
- Reset pulse mid-neuron, then reset pulse while S_OUT with `out_ready`=0:
  - all outputs read 0 next cycle;
  - a following `cfg_len`=0 neuron with beat (256,512) → `out_data`=512.
